// File: rtl/add_sub_arbiter_if.sv
// rtl/add_sub_arbiter_if.sv - two-requester handshake and result bus for add_sub_arbiter
interface add_sub_arbiter_if #(
  parameter int WIDTH = 3
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             m0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             m1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy;

  modport master (
    output req0, a0, b0, m0, req1, a1, b1, m1,
    input  gnt0, gnt1, done0, done1, sum_out, carry_out, busy
  );

  modport slave (
    input  req0, a0, b0, m0, req1, a1, b1, m1,
    output gnt0, gnt1, done0, done1, sum_out, carry_out, busy
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// rtl/add_sub_arbiter.sv - round-robin shared ripple-carry adder/subtractor, one op per 4 cycles
module add_sub_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  add_sub_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             m_q, m_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;

  logic             pick;
  logic [WIDTH-1:0] dp_sum;
  logic [WIDTH:0]   dp_c;

  // Full-adder chain fed from the captured operands; m inverts b and injects the +1.
  assign dp_c[0] = m_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic bx;
    assign bx        = b_q[i] ^ m_q;
    assign dp_sum[i] = a_q[i] ^ bx ^ dp_c[i];
    assign dp_c[i+1] = (a_q[i] & bx) | (dp_c[i] & (a_q[i] ^ bx));
  end

  // With both requesting the pointer decides; otherwise whoever asks wins.
  assign pick = (bus.req0 & bus.req1) ? rr_q : bus.req1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          owner_d = pick;
          a_d     = pick ? bus.a1 : bus.a0;
          b_d     = pick ? bus.b1 : bus.b0;
          m_d     = pick ? bus.m1 : bus.m0;
          rr_d    = ~pick;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: state_d = EXEC;
      EXEC: begin
        sum_d   = dp_sum;
        carry_d = dp_c[WIDTH];
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = busy_q;
endmodule
